seg7_scan_display: RTL and testbench

Parametrised multiplexed seven-segment driver, the successor to the fixed 4-digit scanner. It supports N digits, per-digit decimal points and blanking, and leading-zero suppression. It adds PWM brightness control and tear-free frame-synchronous data update. It sits between the numeric/text producers (random-number, counter blocks) and the board's common-anode display pins.

---
 rtl/seg7_scan_display.sv | 247 ++++++++++++++++++++++++
 tb/tb_seg7_scan_display.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Multiplexed N-digit seven-segment scanner for common-anode displays.
// Features: per-digit decimal point and blanking, leading-zero suppression,
// PWM brightness and frame-synchronous (tear-free) data update.
// Optional feature macro: SEG7_BLINK_EN adds a blink_mask input and a
// frame counter that periodically hides the masked digits.
// All outputs (seg, dp, an, frame_done) are active low except frame_done,
// and are registered one cycle behind the slot timer / digit index.
module seg7_scan_display #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned BRIGHT_W   = 4,
  parameter int unsigned BLINK_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   text,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  input  logic                  lz_suppress,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned      IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  // Elaboration-time guard against unsupported parameter combinations
  if ((DIGITS < 1) || (DIGITS > 8) || (BRIGHT_W > DIV_W) || (BRIGHT_W < 1) ||
      (BLINK_LOG2 < 1)) begin : g_param_check
    $error("seg7_scan_display: unsupported parameter combination");
  end

  // Scan state
  logic [DIV_W-1:0]    r_timer;
  logic [IDX_W-1:0]    r_idx;
  logic                r_frame_done;

  // Shadow (captured by load) and active (displayed) data sets
  logic [4*DIGITS-1:0] r_sh_text;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_sh_blank;
  logic [4*DIGITS-1:0] r_act_text;
  logic [DIGITS-1:0]   r_act_dp;
  logic [DIGITS-1:0]   r_act_blank;
  logic                r_pending;

  // Registered display outputs
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  // Combinational helpers
  logic                w_slot_end;
  logic                w_frame_end;
  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_zero_up;
  logic [DIGITS-1:0]   w_an_sel;
  logic [3:0]          w_cur_nib;
  logic                w_suppress;
  logic [BRIGHT_W-1:0] w_top;
  logic                w_pwm_on;
  logic                w_blink_hide;
  logic                w_lit;

  assign w_slot_end  = &r_timer;
  assign w_frame_end = w_slot_end && (r_idx == LAST_IDX);

  // Active-low segment pattern for one hex nibble, seg[0] = a ... seg[6] = g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] on_pat;
    case (v)
      4'h0:    on_pat = 7'h3F;
      4'h1:    on_pat = 7'h06;
      4'h2:    on_pat = 7'h5B;
      4'h3:    on_pat = 7'h4F;
      4'h4:    on_pat = 7'h66;
      4'h5:    on_pat = 7'h6D;
      4'h6:    on_pat = 7'h7D;
      4'h7:    on_pat = 7'h07;
      4'h8:    on_pat = 7'h7F;
      4'h9:    on_pat = 7'h6F;
      4'hA:    on_pat = 7'h77;
      4'hB:    on_pat = 7'h7C;
      4'hC:    on_pat = 7'h39;
      4'hD:    on_pat = 7'h5E;
      4'hE:    on_pat = 7'h79;
      default: on_pat = 7'h71;
    endcase
    return ~on_pat;
  endfunction

  // Free-running slot timer; digit index advances when the timer wraps
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_timer <= '0;
      r_idx   <= '0;
    end else begin
      r_timer <= r_timer + DIV_W'(1);
      if (w_slot_end) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Frame pulse coincides with the index returning to digit 0
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
    end
  end

  // Load into shadow; promote shadow to active only at a frame boundary.
  // A load landing exactly on the boundary bypasses the shadow stage.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_sh_text   <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_act_text  <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_pending   <= 1'b0;
    end else if (load && w_frame_end) begin
      r_sh_text   <= text;
      r_sh_dp     <= dp_in;
      r_sh_blank  <= blank_in;
      r_act_text  <= text;
      r_act_dp    <= dp_in;
      r_act_blank <= blank_in;
      r_pending   <= 1'b0;
    end else if (load) begin
      r_sh_text   <= text;
      r_sh_dp     <= dp_in;
      r_sh_blank  <= blank_in;
      r_pending   <= 1'b1;
    end else if (w_frame_end && r_pending) begin
      r_act_text  <= r_sh_text;
      r_act_dp    <= r_sh_dp;
      r_act_blank <= r_sh_blank;
      r_pending   <= 1'b0;
    end
  end

`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0]     r_sh_blink;
  logic [DIGITS-1:0]     r_act_blink;
  logic                  r_blink_pending;
  logic [BLINK_LOG2-1:0] r_frame_cnt;
  logic                  r_blink_off;

  // Blink mask follows the same shadow/active handshake as the other data
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_sh_blink      <= '0;
      r_act_blink     <= '0;
      r_blink_pending <= 1'b0;
    end else if (load && w_frame_end) begin
      r_sh_blink      <= blink_mask;
      r_act_blink     <= blink_mask;
      r_blink_pending <= 1'b0;
    end else if (load) begin
      r_sh_blink      <= blink_mask;
      r_blink_pending <= 1'b1;
    end else if (w_frame_end && r_blink_pending) begin
      r_act_blink     <= r_sh_blink;
      r_blink_pending <= 1'b0;
    end
  end

  // Frame counter; phase flips each time the counter wraps
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_frame_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + BLINK_LOG2'(1);
      if (&r_frame_cnt) begin
        r_blink_off <= ~r_blink_off;
      end
    end
  end

  assign w_blink_hide = r_blink_off && r_act_blink[r_idx];
`else
  assign w_blink_hide = 1'b0;
`endif

  // Split active text into nibbles; w_zero_up[i] = nibble i and all above are 0
  always_comb begin
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_nib[i] = r_act_text[4*i +: 4];
    end
    w_zero_up             = '0;
    w_zero_up[DIGITS-1]   = (w_nib[DIGITS-1] == 4'h0);
    for (int unsigned k = 1; k < DIGITS; k++) begin
      w_zero_up[DIGITS-1-k] = (w_nib[DIGITS-1-k] == 4'h0) && w_zero_up[DIGITS-k];
    end
  end

  // One-hot select of the digit currently being scanned
  always_comb begin
    w_an_sel = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_an_sel[i] = (r_idx == IDX_W'(i));
    end
  end

  assign w_cur_nib  = w_nib[r_idx];
  assign w_suppress = lz_suppress && (r_idx != '0) && w_zero_up[r_idx];
  assign w_top      = r_timer[DIV_W-1 -: BRIGHT_W];
  assign w_pwm_on   = (&brightness) || (w_top < brightness);
  // Timer==0 is the anode-changeover cycle and is always dark
  assign w_lit      = w_pwm_on && (r_timer != '0) && !r_act_blank[r_idx] &&
                      !w_blink_hide;

  // Register the display drive so no input reaches the pins combinationally
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_an  <= '1;
      r_seg <= '1;
      r_dp  <= 1'b1;
    end else if (w_lit) begin
      r_an  <= ~w_an_sel;
      r_seg <= w_suppress ? 7'h7F : hex_to_seg(w_cur_nib);
      r_dp  <= ~r_act_dp[r_idx];
    end else begin
      r_an  <= '1;
      r_seg <= '1;
      r_dp  <= 1'b1;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with DIGITS=4, DIV_W=4, BRIGHT_W=4.
// Cycle index n counts rising edges since reset release; outputs at n
// reflect timer/index state n-1 (slot = 16 cycles, frame = 64 cycles).
module tb_seg7_scan_display;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned DIV_W    = 4;
  localparam int unsigned BRIGHT_W = 4;

  logic        clk         = 1'b0;
  logic        arst        = 1'b1;
  logic        load        = 1'b0;
  logic [15:0] text        = '0;
  logic [3:0]  dp_in       = '0;
  logic [3:0]  blank_in    = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness  = 4'hF;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask  = '0;
`endif
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int n        = 0;
  int cnt;

  seg7_scan_display #(
    .DIGITS     (DIGITS),
    .DIV_W      (DIV_W),
    .BRIGHT_W   (BRIGHT_W),
    .BLINK_LOG2 (1)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .load        (load),
    .text        (text),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
`ifdef SEG7_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (n=%0d): got %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [3:0] e_an,
                            input logic [6:0] e_seg, input logic e_dp);
    check({tag, ".an"},  {12'h0, an},  {12'h0, e_an});
    check({tag, ".seg"}, {9'h0, seg},  {9'h0, e_seg});
    check({tag, ".dp"},  {15'h0, dp},  {15'h0, e_dp});
  endtask

  task automatic step_to(input int target);
    while (n < target) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // One-cycle load strobe, sampled by the next rising edge
  task automatic load_pulse(input logic [15:0] t, input logic [3:0] d, input logic [3:0] b);
    text     = t;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
    @(posedge clk);
    #1;
    n++;
    load     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    arst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_disp("rst", 4'hF, 7'h7F, 1'b1);
    check("rst.fd", {15'h0, frame_done}, 16'h0);
    arst = 1'b0;
    n    = 0;

    // Frame 0 shows the reset active data (all zero); 1234 is pending
    load_pulse(16'h1234, 4'h0, 4'h0);
    check_disp("f0.t0", 4'hF, 7'h7F, 1'b1);
    step_to(2);   check_disp("f0.d0", 4'hE, 7'h40, 1'b1);
    step_to(17);  check_disp("f0.d1_t0", 4'hF, 7'h7F, 1'b1);
    step_to(18);  check_disp("f0.d1", 4'hD, 7'h40, 1'b1);
    step_to(63);  check("fd.63", {15'h0, frame_done}, 16'h0);
    step_to(64);  check("fd.64", {15'h0, frame_done}, 16'h1);
    step_to(65);  check("fd.65", {15'h0, frame_done}, 16'h0);
                  check("f1.t0.an", {12'h0, an}, 16'h000F);

    // Frame 1: 1234 scanned right to left
    step_to(66);  check_disp("f1.d0", 4'hE, 7'h19, 1'b1);
    step_to(82);  check_disp("f1.d1", 4'hD, 7'h30, 1'b1);
    step_to(98);  check_disp("f1.d2", 4'hB, 7'h24, 1'b1);
    step_to(114); check_disp("f1.d3", 4'h7, 7'h79, 1'b1);
    step_to(127); check("fd.127", {15'h0, frame_done}, 16'h0);
    step_to(128); check("fd.128", {15'h0, frame_done}, 16'h1);

    // Tear-free: load ABCD during frame 2 slot 1
    step_to(150);
    load_pulse(16'hABCD, 4'h0, 4'h0);
    step_to(162); check_disp("tear.f2.d2", 4'hB, 7'h24, 1'b1);
    step_to(178); check_disp("tear.f2.d3", 4'h7, 7'h79, 1'b1);
    step_to(194); check_disp("tear.f3.d0", 4'hE, 7'h21, 1'b1);
    step_to(210); check_disp("tear.f3.d1", 4'hD, 7'h46, 1'b1);
    step_to(226); check_disp("tear.f3.d2", 4'hB, 7'h03, 1'b1);
    step_to(242); check_disp("tear.f3.d3", 4'h7, 7'h08, 1'b1);

    // Load on the boundary cycle: 0040 with dp on digit 2, LZ on
    step_to(255);
    lz_suppress = 1'b1;
    load_pulse(16'h0040, 4'b0100, 4'h0);
    check("fd.256", {15'h0, frame_done}, 16'h1);
    step_to(258); check_disp("lz.f4.d0", 4'hE, 7'h40, 1'b1);
    step_to(274); check_disp("lz.f4.d1", 4'hD, 7'h19, 1'b1);
    step_to(290); check_disp("lz.f4.d2", 4'hB, 7'h7F, 1'b0);
    step_to(300);
    load_pulse(16'h0000, 4'h0, 4'h0);
    step_to(306); check_disp("lz.f4.d3", 4'h7, 7'h7F, 1'b1);
    step_to(322); check_disp("lz0.f5.d0", 4'hE, 7'h40, 1'b1);
    step_to(338); check_disp("lz0.f5.d1", 4'hD, 7'h7F, 1'b1);
    step_to(354); check_disp("lz0.f5.d2", 4'hB, 7'h7F, 1'b1);

    // Per-digit blanking of digit 1, LZ off
    step_to(360);
    lz_suppress = 1'b0;
    load_pulse(16'h1234, 4'h0, 4'b0010);
    step_to(386); check_disp("blank.f6.d0", 4'hE, 7'h19, 1'b1);
    step_to(402); check_disp("blank.f6.d1", 4'hF, 7'h7F, 1'b1);

    // Brightness 4: lit only for timer 1..3
    step_to(410);
    brightness = 4'h4;
    step_to(417); check("pwm4.t0.an", {12'h0, an}, 16'h000F);
    step_to(418); check_disp("pwm4.t1", 4'hB, 7'h24, 1'b1);
    step_to(420); check("pwm4.t3.an", {12'h0, an}, 16'h000B);
    step_to(421); check("pwm4.t4.an", {12'h0, an}, 16'h000F);
    step_to(432);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step_to(n + 1);
      if (an != 4'hF) cnt++;
    end
    check("pwm4.slot_cnt", 16'(cnt), 16'd3);

    // Brightness 0: dark for a whole frame
    brightness = 4'h0;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step_to(n + 1);
      if (an != 4'hF) cnt++;
    end
    check("pwm0.frame_cnt", 16'(cnt), 16'd0);

    // Asynchronous reset in the middle of a lit slot
    brightness = 4'hF;
    step_to(523); check_disp("pre_arst", 4'hE, 7'h19, 1'b1);
    #3;
    arst = 1'b1;
    #1;
    check_disp("arst.async", 4'hF, 7'h7F, 1'b1);
    check("arst.fd", {15'h0, frame_done}, 16'h0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    n    = 0;
    step_to(1);   check("rel.t0.an", {12'h0, an}, 16'h000F);
    step_to(2);   check_disp("rel.d0", 4'hE, 7'h40, 1'b1);

    // Blink phase: digit 0 masked, BLINK_LOG2=1 -> on for frames 0-1, 4-5
`ifdef SEG7_BLINK_EN
    blink_mask = 4'b0001;
`endif
    load_pulse(16'h1234, 4'h0, 4'h0);
    step_to(66);  check_disp("blk.f1.d0", 4'hE, 7'h19, 1'b1);
`ifdef SEG7_BLINK_EN
    step_to(130); check_disp("blk.f2.d0", 4'hF, 7'h7F, 1'b1);
    step_to(146); check_disp("blk.f2.d1", 4'hD, 7'h30, 1'b1);
    step_to(194); check_disp("blk.f3.d0", 4'hF, 7'h7F, 1'b1);
    step_to(258); check_disp("blk.f4.d0", 4'hE, 7'h19, 1'b1);
    step_to(274); check_disp("blk.f4.d1", 4'hD, 7'h30, 1'b1);
    step_to(386); check_disp("blk.f6.d0", 4'hF, 7'h7F, 1'b1);
`else
    step_to(130); check_disp("noblk.f2.d0", 4'hE, 7'h19, 1'b1);
    step_to(194); check_disp("noblk.f3.d0", 4'hE, 7'h19, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
